// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the rhythm-game flow controller: the flow state
// encoding seen on the 'state' output and the "no song" identifier.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_MENU      = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PLAY      = 3'd3,
        ST_PAUSE     = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    localparam int SONG_NONE = 0;

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions one raw, asynchronous, active-high button: 2-FF synchroniser,
// then a stability counter. The debounced level flips only after DEBOUNCE_CYC
// consecutive equal synchronised samples; a one-cycle press pulse follows a
// debounced 0->1 transition. Raw edge to press pulse: 2 + DEBOUNCE_CYC + 1.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   raw    in   raw button input (asynchronous)
//   level  out  debounced button level
//   press  out  one-cycle pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others (the synchroniser chain depends on it).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any sample agreeing with the current level restarts the count,
            // so a bouncing input never accumulates enough samples to flip.
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Game-flow controller for the LED-matrix rhythm game. Conditions all buttons,
// runs the START/MENU/COUNTDOWN/PLAY/PAUSE/FINISH flow, selects a song and
// keeps a best-score table indexed by song ID (1..NUM_SONGS).
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   btn_lane     raw lane buttons (lane 0 = menu prev, lane 1 = menu next)
//   btn_confirm  raw confirm button
//   btn_back     raw back / pause button
//   song_finish  level from the note loader: song has ended
//   score        running score from the scorer
//   state        flow state (game_pkg::state_t encoding)
//   song_sel     menu cursor
//   song_id      song in progress, 0 when none
//   song_start   pulse on COUNTDOWN->PLAY
//   song_abort   pulse on PAUSE->MENU
//   play_en      high only in PLAY
//   lane_press   debounced lane press pulses, forwarded only in PLAY
//   count_val    remaining count-in steps, 0 outside COUNTDOWN
//   best_score   best score of the song under the menu cursor
//   new_best     pulse when the table receives a new best
// -----------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int NUM_SONGS    = 3,
    parameter int SCORE_W      = 16,
    parameter int DEBOUNCE_CYC = 16,
    parameter int COUNT_CYC    = 1024,
    parameter int COUNT_STEPS  = 3,
    localparam int SEL_W       = $clog2(NUM_SONGS + 1),
    localparam int CNT_W       = $clog2(COUNT_STEPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] btn_lane,
    input  logic                 btn_confirm,
    input  logic                 btn_back,
    input  logic                 song_finish,
    input  logic [SCORE_W-1:0]   score,
    output logic [2:0]           state,
    output logic [SEL_W-1:0]     song_sel,
    output logic [SEL_W-1:0]     song_id,
    output logic                 song_start,
    output logic                 song_abort,
    output logic                 play_en,
    output logic [NUM_LANES-1:0] lane_press,
    output logic [CNT_W-1:0]     count_val,
    output logic [SCORE_W-1:0]   best_score,
    output logic                 new_best
);

    localparam int NB    = NUM_LANES + 2;
    localparam int TMR_W = $clog2(COUNT_CYC + 1);

    // ---------------- button conditioning ----------------
    logic [NB-1:0] raw_btn;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] unused_level;   // debounced levels are not consumed here

    assign raw_btn = {btn_back, btn_confirm, btn_lane};

    for (genvar g = 0; g < NB; g++) begin : g_cond
        btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_btn[g]),
            .level (unused_level[g]),
            .press (btn_press[g])
        );
    end

    logic [NUM_LANES-1:0] lane_pr;
    logic                 confirm_pr;
    logic                 back_pr;
    logic                 prev_pr;
    logic                 next_pr;

    assign lane_pr    = btn_press[NUM_LANES-1:0];
    assign confirm_pr = btn_press[NUM_LANES];
    assign back_pr    = btn_press[NUM_LANES+1];
    assign prev_pr    = lane_pr[0];
    assign next_pr    = lane_pr[1];

    // ---------------- flow state and registers ----------------
    state_t              cur_st, nxt_st;
    logic [SEL_W-1:0]    sel_nxt, id_nxt;
    logic [CNT_W-1:0]    cv_nxt;
    logic [TMR_W-1:0]    step_tmr, tmr_nxt;
    logic                start_nxt, abort_nxt, best_we;
    logic                fin_first;    // first cycle spent in FINISH
    logic [SCORE_W-1:0]  best_tbl [1:NUM_SONGS];

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nxt_st    = cur_st;
        sel_nxt   = song_sel;
        id_nxt    = song_id;
        cv_nxt    = count_val;
        tmr_nxt   = step_tmr;
        start_nxt = 1'b0;
        abort_nxt = 1'b0;
        best_we   = 1'b0;

        case (cur_st)
            ST_START: begin
                if (|lane_pr) nxt_st = ST_MENU;
            end
            ST_MENU: begin
                if (prev_pr && !next_pr) begin
                    sel_nxt = (song_sel == SEL_W'(1)) ? SEL_W'(NUM_SONGS) : song_sel - 1'b1;
                end else if (next_pr && !prev_pr) begin
                    sel_nxt = (song_sel == SEL_W'(NUM_SONGS)) ? SEL_W'(1) : song_sel + 1'b1;
                end
                if (confirm_pr) begin
                    nxt_st  = ST_COUNTDOWN;
                    id_nxt  = song_sel;
                    cv_nxt  = CNT_W'(COUNT_STEPS);
                    tmr_nxt = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (back_pr) begin
                    nxt_st = ST_MENU;
                    id_nxt = SEL_W'(SONG_NONE);
                    cv_nxt = '0;
                end else if (step_tmr == TMR_W'(COUNT_CYC - 1)) begin
                    tmr_nxt = '0;
                    cv_nxt  = count_val - 1'b1;
                    if (count_val == CNT_W'(1)) begin
                        nxt_st    = ST_PLAY;
                        start_nxt = 1'b1;
                    end
                end else begin
                    tmr_nxt = step_tmr + 1'b1;
                end
            end
            ST_PLAY: begin
                // The song ending takes priority over a simultaneous pause.
                if (song_finish)  nxt_st = ST_FINISH;
                else if (back_pr) nxt_st = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (back_pr) begin
                    nxt_st    = ST_MENU;
                    id_nxt    = SEL_W'(SONG_NONE);
                    abort_nxt = 1'b1;
                end else if (confirm_pr) begin
                    nxt_st = ST_PLAY;
                end
            end
            ST_FINISH: begin
                best_we = fin_first && (score > best_tbl[song_id]);
                if (confirm_pr) begin
                    nxt_st = ST_MENU;
                    id_nxt = SEL_W'(SONG_NONE);
                end
            end
            default: nxt_st = ST_START;
        endcase
    end

    // NOTE: the score table is reset explicitly because a reset must clear
    // all best scores; it is a handful of flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st     <= ST_START;
            song_sel   <= SEL_W'(1);
            song_id    <= SEL_W'(SONG_NONE);
            count_val  <= '0;
            step_tmr   <= '0;
            song_start <= 1'b0;
            song_abort <= 1'b0;
            new_best   <= 1'b0;
            fin_first  <= 1'b0;
            for (int i = 1; i <= NUM_SONGS; i++) best_tbl[i] <= '0;
        end else begin
            cur_st     <= nxt_st;
            song_sel   <= sel_nxt;
            song_id    <= id_nxt;
            count_val  <= cv_nxt;
            step_tmr   <= tmr_nxt;
            song_start <= start_nxt;
            song_abort <= abort_nxt;
            new_best   <= best_we;
            fin_first  <= (cur_st != ST_FINISH) && (nxt_st == ST_FINISH);
            if (best_we) best_tbl[song_id] <= score;
        end
    end

    assign state      = cur_st;
    assign play_en    = (cur_st == ST_PLAY);
    assign lane_press = lane_pr & {NUM_LANES{cur_st == ST_PLAY}};
    assign best_score = best_tbl[song_sel];

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Scoreboard bench for game_flow_ctrl with DEBOUNCE_CYC=4, COUNT_CYC=8,
// COUNT_STEPS=3, NUM_SONGS=3. Stimulus pushes expected output events (name,
// value, cycle) into a queue; a negedge monitor detects every output change
// or pulse and pops/compares in a fixed per-cycle order:
// state, sel, id, count, start, abort, best, lane.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = 4'b0;      // {back, confirm, lane1, lane0}
    logic        song_finish = 1'b0;
    logic [15:0] score = 16'd0;

    logic [2:0]  state;
    logic [1:0]  song_sel, song_id, count_val, lane_press;
    logic        song_start, song_abort, play_en, new_best;
    logic [15:0] best_score;

    game_flow_ctrl #(
        .NUM_LANES(2), .NUM_SONGS(3), .SCORE_W(16),
        .DEBOUNCE_CYC(4), .COUNT_CYC(8), .COUNT_STEPS(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_lane    (btn[1:0]),
        .btn_confirm (btn[2]),
        .btn_back    (btn[3]),
        .song_finish (song_finish),
        .score       (score),
        .state       (state),
        .song_sel    (song_sel),
        .song_id     (song_id),
        .song_start  (song_start),
        .song_abort  (song_abort),
        .play_en     (play_en),
        .lane_press  (lane_press),
        .count_val   (count_val),
        .best_score  (best_score),
        .new_best    (new_best)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    value;
        int    at;
    } ev_t;

    ev_t q[$];

    task automatic exp_ev(input string name, input int value, input int at);
        ev_t e;
        e.name  = name;
        e.value = value;
        e.at    = at;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic got(input string name, input int value);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected event %s=%0d at cyc %0d", name, value, cyc);
        end else begin
            e = q.pop_front();
            if (e.name != name || e.value != value || e.at != cyc) begin
                errors++;
                $display("FAIL event: got %s=%0d @%0d, expected %s=%0d @%0d",
                         name, value, cyc, e.name, e.value, e.at);
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_en = 1'b0;
    logic [2:0] p_state = 3'd0;
    logic [1:0] p_sel = 2'd1, p_id = 2'd0, p_cv = 2'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (state != p_state)    got("state", int'(state));
            if (song_sel != p_sel)   got("sel", int'(song_sel));
            if (song_id != p_id)     got("id", int'(song_id));
            if (count_val != p_cv)   got("count", int'(count_val));
            if (song_start)          got("start", int'(song_id));
            if (song_abort)          got("abort", int'(song_id));
            if (new_best)            got("best", int'(best_score));
            if (|lane_press)         got("lane", int'(lane_press));
            p_state = state;
            p_sel   = song_sel;
            p_id    = song_id;
            p_cv    = count_val;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Hold buttons for 8 cycles, release for 8 (long enough to re-debounce).
    task automatic press(input logic [3:0] m);
        btn = m;
        repeat (8) @(negedge clk);
        btn = 4'b0;
        repeat (8) @(negedge clk);
    endtask

    // From MENU with the cursor on 'sel': confirm and ride the count-in.
    task automatic run_to_play(input int sel);
        int t;
        t = cyc;
        exp_ev("state", 2, t + 8);
        exp_ev("id", sel, t + 8);
        exp_ev("count", 3, t + 8);
        exp_ev("count", 2, t + 16);
        exp_ev("count", 1, t + 24);
        exp_ev("state", 3, t + 32);
        exp_ev("count", 0, t + 32);
        exp_ev("start", sel, t + 32);
        press(4'b0100);
        wait_until(t + 33);
        check("play_en_in_play", int'(play_en), 1);
        check("song_id_in_play", int'(song_id), sel);
    endtask

    // Finish the running song with a given score; expect a new best or not.
    task automatic finish_song(input int sc, input bit is_best);
        int t;
        score = 16'(sc);
        t = cyc;
        exp_ev("state", 5, t + 1);
        if (is_best) exp_ev("best", sc, t + 2);
        song_finish = 1'b1;
        @(negedge clk);
        song_finish = 1'b0;
        wait_until(t + 3);
        check("play_en_finish", int'(play_en), 0);
    endtask

    task automatic confirm_to_menu();
        int t;
        t = cyc;
        exp_ev("state", 1, t + 8);
        exp_ev("id", 0, t + 8);
        press(4'b0100);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_state", int'(state), 0);
        check("rst_sel", int'(song_sel), 1);
        check("rst_id", int'(song_id), 0);
        check("rst_count", int'(count_val), 0);
        check("rst_play_en", int'(play_en), 0);
        check("rst_best", int'(best_score), 0);
        mon_en = 1'b1;

        // 1: bouncing lane 1 in START, then held: one press, 7 cycles after
        // the final rise, moves to MENU on the following edge.
        for (int i = 0; i < 3; i++) begin
            btn = 4'b0010; repeat (2) @(negedge clk);
            btn = 4'b0000; repeat (2) @(negedge clk);
        end
        t = cyc;
        exp_ev("state", 1, t + 8);
        press(4'b0010);

        // 2: menu wrap and simultaneous prev/next; back ignored in MENU
        t = cyc; exp_ev("sel", 3, t + 8); press(4'b0001);
        t = cyc; exp_ev("sel", 1, t + 8); press(4'b0010);
        press(4'b0011);
        check("sel_prev_next_same", int'(song_sel), 1);
        press(4'b1000);
        check("menu_back_ignored", int'(state), 1);

        // 3: flow for song 2, lane forwarding in PLAY
        t = cyc; exp_ev("sel", 2, t + 8); press(4'b0010);
        run_to_play(2);
        t = cyc; exp_ev("lane", 1, t + 7); press(4'b0001);

        // 4: best-score table for song 2
        finish_song(500, 1'b1);
        check("best_500", int'(best_score), 500);
        confirm_to_menu();
        check("sel_after_finish", int'(song_sel), 2);
        run_to_play(2);
        finish_song(500, 1'b0);
        confirm_to_menu();
        run_to_play(2);
        finish_song(501, 1'b1);
        check("best_501", int'(best_score), 501);
        confirm_to_menu();

        // 5: pause, blocked lanes, resume, abort; finish beats back
        run_to_play(2);
        t = cyc; exp_ev("state", 4, t + 8); press(4'b1000);
        press(4'b0010);
        check("pause_blocks_lane", int'(state), 4);
        t = cyc; exp_ev("state", 3, t + 8); press(4'b0100);
        t = cyc; exp_ev("state", 4, t + 8); press(4'b1000);
        t = cyc;
        exp_ev("state", 1, t + 8);
        exp_ev("id", 0, t + 8);
        exp_ev("abort", 0, t + 8);
        press(4'b1000);
        run_to_play(2);
        t = cyc;
        exp_ev("state", 5, t + 8);
        btn = 4'b1000;
        wait_until(t + 7);
        song_finish = 1'b1;
        @(negedge clk);
        song_finish = 1'b0;
        btn = 4'b0000;
        repeat (8) @(negedge clk);
        check("finish_beats_back", int'(state), 5);
        confirm_to_menu();

        // 6: one-cycle reset in PLAY
        run_to_play(2);
        t = cyc;
        exp_ev("state", 0, t + 1);
        exp_ev("sel", 1, t + 1);
        exp_ev("id", 0, t + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", int'(state), 0);
        check("rst_mid_sel", int'(song_sel), 1);
        check("rst_mid_play_en", int'(play_en), 0);
        t = cyc; exp_ev("state", 1, t + 8); press(4'b0010);
        t = cyc; exp_ev("sel", 2, t + 8); press(4'b0010);
        check("table_cleared", int'(best_score), 0);

        repeat (4) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
